seg7_scan_ctrl: RTL and testbench

- Memory-mapped 8-digit seven-segment display controller on the CPU IO bus, peer of the LED and switch peripherals.
- Consumes the IO write path: the chip select from the memory/IO decoder, the low address bits and the 32-bit write data.
- Holds display registers and time-multiplexes eight common-anode digits with an anti-ghosting blank window.
- Supports register readback on the IO read path.

---
 rtl/seg7_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Memory-mapped 8-digit common-anode seven-segment controller.
// Holds the display registers, scans the digits with a blank window, and supports IO readback.
module seg7_scan_ctrl #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 200,
  parameter int unsigned CNT_W     = 17
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ioWrite,
  input  logic        ioRead,
  input  logic        segCtrl,
  input  logic [1:0]  seg_addr,
  input  logic [31:0] seg_wdata,
  output logic [15:0] seg_rdata,
  output logic [7:0]  seg_en,
  output logic [7:0]  seg_out
);

  logic [15:0]      r_dlo;
  logic [15:0]      r_dhi;
  logic [7:0]       r_mask;
  logic [7:0]       r_dp;
  logic [1:0]       r_ctrl;
  logic [15:0]      r_rdata;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_en;
  logic [7:0]       r_out;

  logic        w_wr;
  logic        w_rd;
  logic [15:0] w_rd_mux;
  logic [31:0] w_digits;
  logic [3:0]  w_nib;
  logic        w_blank;
  logic        w_lz;
  logic [7:0]  w_en_d;
  logic [7:0]  w_out_d;
  logic        w_unused;

  assign w_wr     = segCtrl & ioWrite;
  assign w_rd     = segCtrl & ioRead;
  assign w_unused = ^seg_wdata[31:16];

  function automatic logic [6:0] hex7(input logic [3:0] v);
    hex7 = 7'h7F;
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      4'hF: hex7 = 7'h0E;
      default: hex7 = 7'h7F;
    endcase
  endfunction

  always_comb begin
    w_rd_mux = 16'h0000;
    case (seg_addr)
      2'd0:    w_rd_mux = r_dlo;
      2'd1:    w_rd_mux = r_dhi;
      2'd2:    w_rd_mux = {r_dp, r_mask};
      default: w_rd_mux = {14'h0000, r_ctrl};
    endcase
  end

  assign w_digits = {r_dhi, r_dlo};
  assign w_nib    = w_digits[{r_idx, 2'b00} +: 4];
  assign w_blank  = r_cnt < CNT_W'(BLANK_CYC);
  // Suppressed when this digit and every higher one are zero; digit 0 always shows.
  assign w_lz     = r_ctrl[1] && (r_idx != 3'd0) && ((w_digits >> {r_idx, 2'b00}) == 32'd0);

  always_comb begin
    w_en_d  = 8'hFF;
    w_out_d = 8'hFF;
    if (!w_blank && r_ctrl[0] && r_mask[r_idx]) begin
      w_en_d = ~(8'b0000_0001 << r_idx);
      if (!w_lz) begin
        w_out_d = {~r_dp[r_idx], hex7(w_nib)};
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dlo   <= 16'h0000;
      r_dhi   <= 16'h0000;
      r_mask  <= 8'hFF;
      r_dp    <= 8'h00;
      r_ctrl  <= 2'b01;
      r_rdata <= 16'h0000;
    end else begin
      // Read samples pre-write values, so a same-cycle read sees the old contents.
      if (w_rd) begin
        r_rdata <= w_rd_mux;
      end
      if (w_wr) begin
        case (seg_addr)
          2'd0: r_dlo <= seg_wdata[15:0];
          2'd1: r_dhi <= seg_wdata[15:0];
          2'd2: begin
            r_mask <= seg_wdata[7:0];
            r_dp   <= seg_wdata[15:8];
          end
          default: r_ctrl <= seg_wdata[1:0];
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_idx <= 3'd0;
      r_en  <= 8'hFF;
      r_out <= 8'hFF;
    end else begin
      if (r_cnt == CNT_W'(SCAN_DIV - 1)) begin
        r_cnt <= '0;
        r_idx <= r_idx + 3'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_en  <= w_en_d;
      r_out <= w_out_d;
    end
  end

  assign seg_rdata = r_rdata;
  assign seg_en    = r_en;
  assign seg_out   = r_out;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2.
// Stimulus queues hand-computed expectations; a negedge monitor pops and compares them.
module tb_seg7_scan_ctrl;

  logic        clock;
  logic        reset;
  logic        ioWrite;
  logic        ioRead;
  logic        segCtrl;
  logic [1:0]  seg_addr;
  logic [31:0] seg_wdata;
  logic [15:0] seg_rdata;
  logic [7:0]  seg_en;
  logic [7:0]  seg_out;

  seg7_scan_ctrl #(
    .SCAN_DIV (8),
    .BLANK_CYC(2),
    .CNT_W    (3)
  ) u_dut (
    .clock    (clock),
    .reset    (reset),
    .ioWrite  (ioWrite),
    .ioRead   (ioRead),
    .segCtrl  (segCtrl),
    .seg_addr (seg_addr),
    .seg_wdata(seg_wdata),
    .seg_rdata(seg_rdata),
    .seg_en   (seg_en),
    .seg_out  (seg_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          is_rd;
    string       name;
    logic [7:0]  en;
    logic [7:0]  out;
    logic [15:0] rd;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   tb_n;

  // Edges since reset release; output register after edge n reflects scan slot n-1.
  always @(posedge clock or negedge reset) begin
    if (!reset) tb_n <= 0;
    else        tb_n <= tb_n + 1;
  end

  always @(negedge clock) begin
    while (q.size() > 0) begin
      m_e = q.pop_front();
      n_checks++;
      if (m_e.is_rd) begin
        if (seg_rdata !== m_e.rd) begin
          n_fail++;
          $display("FAIL %s: seg_rdata=%h expected %h", m_e.name, seg_rdata, m_e.rd);
        end
      end else if (seg_en !== m_e.en || seg_out !== m_e.out) begin
        n_fail++;
        $display("FAIL %s: seg_en=%h seg_out=%h expected seg_en=%h seg_out=%h",
                 m_e.name, seg_en, seg_out, m_e.en, m_e.out);
      end
    end
  end

  task automatic exp_out(input string nm, input logic [7:0] en, input logic [7:0] out);
    exp_t e;
    e.is_rd = 1'b0; e.name = nm; e.en = en; e.out = out; e.rd = 16'h0;
    q.push_back(e);
  endtask

  task automatic exp_rd(input string nm, input logic [15:0] rd);
    exp_t e;
    e.is_rd = 1'b1; e.name = nm; e.en = 8'h0; e.out = 8'h0; e.rd = rd;
    q.push_back(e);
  endtask

  // Advance until the outputs show digit d at counter c.
  task automatic wait_out(input int d, input int c);
    bit hit = 1'b0;
    for (int i = 0; i < 80 && !hit; i++) begin
      @(posedge clock);
      #1;
      if (((tb_n - 1) % 64) == (d * 8 + c)) hit = 1'b1;
    end
    if (!hit) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_out: digit %0d counter %0d not reached, got slot %0d required %0d",
               d, c, (tb_n - 1) % 64, d * 8 + c);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    segCtrl = 1'b1; ioWrite = 1'b1; ioRead = 1'b0; seg_addr = a; seg_wdata = d;
    @(posedge clock);
    #1;
    segCtrl = 1'b0; ioWrite = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [1:0] a, input logic [15:0] expv);
    segCtrl = 1'b1; ioRead = 1'b1; ioWrite = 1'b0; seg_addr = a;
    @(posedge clock);
    #1;
    segCtrl = 1'b0; ioRead = 1'b0;
    exp_rd(nm, expv);
  endtask

  task automatic rdwr(input string nm, input logic [1:0] a, input logic [31:0] d,
                      input logic [15:0] expv);
    segCtrl = 1'b1; ioRead = 1'b1; ioWrite = 1'b1; seg_addr = a; seg_wdata = d;
    @(posedge clock);
    #1;
    segCtrl = 1'b0; ioRead = 1'b0; ioWrite = 1'b0;
    exp_rd(nm, expv);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; ioWrite = 1'b0; ioRead = 1'b0; segCtrl = 1'b0;
    seg_addr = 2'd0; seg_wdata = 32'h0;

    // 1: reset state and first lit window
    repeat (3) @(posedge clock);
    #1;
    exp_out("reset_out", 8'hFF, 8'hFF);
    exp_rd("reset_rdata", 16'h0000);
    reset = 1'b1;
    wait_out(0, 1); exp_out("d0_blank_c1", 8'hFF, 8'hFF);
    wait_out(0, 2); exp_out("d0_first_lit", 8'hFE, 8'hC0);

    // 2: digit values, lit window edges, 7->0 wrap
    wr(2'd0, 32'hFFFF_1234);
    wr(2'd1, 32'h0000_5678);
    wait_out(0, 2); exp_out("d0_4_c2", 8'hFE, 8'h99);
    wait_out(0, 7); exp_out("d0_4_c7", 8'hFE, 8'h99);
    wait_out(3, 2); exp_out("d3_1", 8'hF7, 8'hF9);
    wait_out(4, 4); exp_out("d4_8", 8'hEF, 8'h80);
    wait_out(7, 7); exp_out("d7_5", 8'h7F, 8'h92);
    wait_out(0, 1); exp_out("wrap_d0_blank", 8'hFF, 8'hFF);
    wait_out(0, 2); exp_out("wrap_d0_lit", 8'hFE, 8'h99);

    // 3: mask and decimal point
    wr(2'd2, 32'h0000_01FE);
    wait_out(0, 2); exp_out("d0_masked_c2", 8'hFF, 8'hFF);
    wait_out(0, 7); exp_out("d0_masked_c7", 8'hFF, 8'hFF);
    wait_out(1, 2); exp_out("d1_3_nodp", 8'hFD, 8'hB0);
    wr(2'd0, 32'h0);
    wr(2'd2, 32'h0000_01FF);
    wait_out(0, 3); exp_out("d0_dp_on", 8'hFE, 8'h40);

    // 4: leading-zero suppress
    wr(2'd2, 32'h0000_00FF);
    wr(2'd0, 32'h0000_0050);
    wr(2'd1, 32'h0);
    wr(2'd3, 32'h3);
    wait_out(0, 2); exp_out("lz_d0", 8'hFE, 8'hC0);
    wait_out(1, 2); exp_out("lz_d1", 8'hFD, 8'h92);
    wait_out(2, 1); exp_out("lz_d2_blank", 8'hFF, 8'hFF);
    wait_out(2, 3); exp_out("lz_d2", 8'hFB, 8'hFF);
    wait_out(7, 7); exp_out("lz_d7", 8'h7F, 8'hFF);

    // 5: display-off latency and readback
    wait_out(4, 3); exp_out("d4_before_off", 8'hEF, 8'hFF);
    wr(2'd3, 32'h0);
    exp_out("off_capture_edge", 8'hEF, 8'hFF);
    @(posedge clock);
    #1;
    exp_out("off_next_edge", 8'hFF, 8'hFF);
    rd("rd_ctrl0", 2'd3, 16'h0000);
    rd("rd_dlo", 2'd0, 16'h0050);
    rd("rd_mask_dp", 2'd2, 16'h00FF);
    rdwr("rdwr_old", 2'd1, 32'h0000_ABCD, 16'h0000);
    rd("rd_dhi_new", 2'd1, 16'hABCD);
    wr(2'd3, 32'hFFFF_FFFF);
    rd("rd_ctrl_masked", 2'd3, 16'h0003);

    // 6: asynchronous reset mid-scan
    wr(2'd0, 32'h0000_1234);
    wr(2'd3, 32'h1);
    wait_out(3, 3); exp_out("d3_pre_reset", 8'hF7, 8'hF9);
    @(posedge clock);
    #2;
    reset = 1'b0;
    exp_out("async_reset_out", 8'hFF, 8'hFF);
    exp_rd("async_reset_rdata", 16'h0000);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    wait_out(0, 1); exp_out("rst_d0_blank", 8'hFF, 8'hFF);
    wait_out(0, 2); exp_out("rst_d0_lit", 8'hFE, 8'hC0);
    rd("rst_rd_dlo", 2'd0, 16'h0000);
    rd("rst_rd_dhi", 2'd1, 16'h0000);
    rd("rst_rd_mask", 2'd2, 16'h00FF);
    rd("rst_rd_ctrl", 2'd3, 16'h0001);

    @(negedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
